// File: rtl/philo_ring.sv
// Parametrised dining-philosopher ring with starvation counters, optional fair grants and a sticky mutex checker.
// Every state updates one cycle after the sampling edge. There is no backpressure: coin is sampled on every edge.
module philo_ring #(
  parameter int N           = 8,
  parameter int INIT_READER = 0,
  parameter int WAIT_W      = 4,
  parameter int MAX_WAIT    = 12,
  parameter int FAIR_MODE   = 0
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   coin,
  output logic [2*N-1:0] state,
  output logic [N-1:0]   starving,
  output logic           mutex_err
);

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } phil_e;

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] SAT_W = '1;
  localparam logic [WAIT_W-1:0] ONE_W = {{(WAIT_W-1){1'b0}}, 1'b1};

  logic [N-1:0] eat, hun, thk, rdg, elig, grant, adj;
  logic         mutex_q, mutex_d;

  for (genvar g = 0; g < N; g++) begin : g_ph
    localparam int    L      = (g + 1) % N;
    localparam int    R      = (g + N - 1) % N;
    localparam bit    L_LO   = (L < g);
    localparam bit    R_LO   = (R < g);
    localparam phil_e RST_ST = (g == INIT_READER) ? READING : THINKING;

    phil_e             st_q, st_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              base;

    assign eat[g]      = (st_q == EATING);
    assign hun[g]      = (st_q == HUNGRY);
    assign thk[g]      = (st_q == THINKING);
    assign rdg[g]      = (st_q == READING);
    assign starving[g] = (wait_q >= MAX_W);
    assign elig[g]     = hun[g] & starving[g] & ~eat[L] & ~eat[R];
    assign base        = ~eat[L] & ~eat[R] & ~hun[R];
    assign adj[g]      = eat[g] & eat[L];
    assign state[2*g +: 2] = st_q;

    // A starving philosopher competes only against eligible lower-index neighbours;
    // others yield to an eligible left neighbour.
    if (FAIR_MODE != 0) begin : g_fair
      assign grant[g] = starving[g]
                      ? (elig[g] & ~(elig[L] & L_LO) & ~(elig[R] & R_LO))
                      : (base & ~elig[L]);
    end else begin : g_base
      assign grant[g] = base;
    end

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        READING:  if (thk[L]) st_d = THINKING;
        THINKING: begin
          if (coin[g] && rdg[R]) st_d = READING;
          else if (!coin[g])     st_d = HUNGRY;
        end
        EATING:   if (coin[g]) st_d = THINKING;
        HUNGRY:   if (grant[g]) st_d = EATING;
        default:  st_d = st_q;
      endcase
      wait_d = '0;
      if (st_q == HUNGRY && st_d == HUNGRY)
        wait_d = (wait_q == SAT_W) ? wait_q : wait_q + ONE_W;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        st_q   <= RST_ST;
        wait_q <= '0;
      end else begin
        st_q   <= st_d;
        wait_q <= wait_d;
      end
    end
  end

  assign mutex_d   = mutex_q | (|adj);
  assign mutex_err = mutex_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mutex_q <= 1'b0;
    else          mutex_q <= mutex_d;
  end

endmodule

// File: tb/tb_philo_ring.sv
// Directed checks of a 4-philosopher ring in base and fair modes, plus a random soak on 5- and 8-rings.
module tb_philo_ring;

  logic        clk = 1'b0;
  logic        rst_n, rst_s_n;
  logic [3:0]  coin_a, coin_b;
  logic [7:0]  st_a, st_b;
  logic [3:0]  sv_a, sv_b;
  logic        me_a, me_b;
  logic [4:0]  c5n, c5f, sv5n, sv5f;
  logic [9:0]  st5n, st5f;
  logic [7:0]  c8n, c8f, sv8n, sv8f;
  logic [15:0] st8n, st8f;
  logic        me5n, me5f, me8n, me8f;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  philo_ring #(.N(4), .INIT_READER(0), .WAIT_W(4), .MAX_WAIT(3), .FAIR_MODE(0)) u_nf (
    .clock(clk), .reset_n(rst_n), .coin(coin_a), .state(st_a), .starving(sv_a), .mutex_err(me_a));
  philo_ring #(.N(4), .INIT_READER(0), .WAIT_W(4), .MAX_WAIT(3), .FAIR_MODE(1)) u_fr (
    .clock(clk), .reset_n(rst_n), .coin(coin_b), .state(st_b), .starving(sv_b), .mutex_err(me_b));
  philo_ring #(.N(5), .INIT_READER(2), .WAIT_W(4), .MAX_WAIT(3), .FAIR_MODE(0)) u_s5n (
    .clock(clk), .reset_n(rst_s_n), .coin(c5n), .state(st5n), .starving(sv5n), .mutex_err(me5n));
  philo_ring #(.N(5), .INIT_READER(2), .WAIT_W(4), .MAX_WAIT(3), .FAIR_MODE(1)) u_s5f (
    .clock(clk), .reset_n(rst_s_n), .coin(c5f), .state(st5f), .starving(sv5f), .mutex_err(me5f));
  philo_ring #(.N(8), .INIT_READER(0), .WAIT_W(4), .MAX_WAIT(3), .FAIR_MODE(0)) u_s8n (
    .clock(clk), .reset_n(rst_s_n), .coin(c8n), .state(st8n), .starving(sv8n), .mutex_err(me8n));
  philo_ring #(.N(8), .INIT_READER(0), .WAIT_W(4), .MAX_WAIT(3), .FAIR_MODE(1)) u_s8f (
    .clock(clk), .reset_n(rst_s_n), .coin(c8f), .state(st8f), .starving(sv8f), .mutex_err(me8f));

  // Hand-derived fair-mode trace for edges 1..13
  localparam logic [7:0] FR_ST [13] = '{8'hFC, 8'hFB, 8'hFB, 8'hFB, 8'hBB, 8'hB3, 8'h3F,
                                        8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hCC, 8'hBB};
  localparam logic [3:0] FR_SV [13] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'h5, 4'h5, 4'h5,
                                        4'h0, 4'h0, 4'h2, 4'hA, 4'hA, 4'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int adj_eat(input logic [15:0] st, input int n);
    for (int i = 0; i < n; i++)
      if (st[2*i +: 2] == 2'd2 && st[2*((i+1)%n) +: 2] == 2'd2) return 1;
    return 0;
  endfunction

  initial begin
    int bad5n, bad5f, bad8n, bad8f;
    rst_n = 1'b0; rst_s_n = 1'b0;
    coin_a = '0; coin_b = '0;
    c5n = '0; c5f = '0; c8n = '0; c8f = '0;

    repeat (2) tick();
    check("rst_state_a", 32'(st_a), 32'h01);
    check("rst_state_b", 32'(st_b), 32'h01);
    check("rst_starv_a", 32'(sv_a), 32'h0);
    check("rst_mutex_a", 32'(me_a), 32'h0);

    rst_n = 1'b1;
    coin_a = 4'b0010; coin_b = 4'b0010;
    tick();
    check("token_a", 32'(st_a), 32'hF4);
    check("token_b", 32'(st_b), 32'hF4);

    rst_n = 1'b0;
    coin_a = '0; coin_b = '0;
    tick();
    rst_n = 1'b1;

    for (int e = 1; e <= 20; e++) begin
      case (e)
        6:       coin_b = 4'b0010;
        7:       coin_b = 4'b1000;
        12:      coin_b = 4'b0101;
        default: coin_b = 4'b0000;
      endcase
      tick();
      check($sformatf("base_state_e%0d", e), 32'(st_a), (e == 1) ? 32'hFC : 32'hFB);
      check($sformatf("base_starv_e%0d", e), 32'(sv_a),
            (e < 4) ? 32'h0 : (e == 4) ? 32'hC : 32'hD);
      check($sformatf("base_mutex_e%0d", e), 32'(me_a), 32'h0);
      if (e <= 13) begin
        check($sformatf("fair_state_e%0d", e), 32'(st_b), 32'(FR_ST[e-1]));
        check($sformatf("fair_starv_e%0d", e), 32'(sv_b), 32'(FR_SV[e-1]));
        check($sformatf("fair_mutex_e%0d", e), 32'(me_b), 32'h0);
      end
    end

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state_a", 32'(st_a), 32'h01);
    check("async_rst_starv_a", 32'(sv_a), 32'h0);
    check("async_rst_mutex_a", 32'(me_a), 32'h0);
    check("async_rst_state_b", 32'(st_b), 32'h01);
    check("async_rst_starv_b", 32'(sv_b), 32'h0);
    tick();
    rst_n = 1'b1;

    bad5n = 0; bad5f = 0; bad8n = 0; bad8f = 0;
    rst_s_n = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      c5n = 5'($urandom); c5f = 5'($urandom);
      c8n = 8'($urandom); c8f = 8'($urandom);
      tick();
      bad5n += adj_eat({6'd0, st5n}, 5);
      bad5f += adj_eat({6'd0, st5f}, 5);
      bad8n += adj_eat(st8n, 8);
      bad8f += adj_eat(st8f, 8);
    end
    check("soak_adj_5n", 32'(bad5n), 32'd0);
    check("soak_adj_5f", 32'(bad5f), 32'd0);
    check("soak_adj_8n", 32'(bad8n), 32'd0);
    check("soak_adj_8f", 32'(bad8f), 32'd0);
    check("soak_mutex_5n", 32'(me5n), 32'h0);
    check("soak_mutex_5f", 32'(me5f), 32'h0);
    check("soak_mutex_8n", 32'(me8n), 32'h0);
    check("soak_mutex_8f", 32'(me8f), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
